// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/writeback stage.
package exec_pkg;

  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned ADDR_W_DEF     = 4;
  localparam int unsigned MUL_CYCLES_DEF = 64;
  localparam int unsigned INSTR_W        = 16;
  localparam int unsigned SHAMT_W        = 6;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 8;
  localparam int unsigned SRC_MSB = 7;
  localparam int unsigned SRC_LSB = 4;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_MOV = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_MUL = 4'h9,
    OP_LDI = 4'hA
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mul64.sv
// Iterative shift-add multiplier: one partial-product step per clock.
module seq_mul64 #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MUL_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done_c,
  output logic [DATA_W-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] acc_sum_c;

  // Accumulator after this cycle's step; on the last step it is the product
  always_comb begin
    acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_c    = busy_q && (cnt_q == CNT_W'(MUL_CYCLES - 1));
    product_c = acc_sum_c;
  end

  // Load on start, otherwise step while busy
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_sum_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done_c) busy_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Single-issue execute/writeback stage in front of register_file.
module alu_exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rf_dst,
  output logic [ADDR_W-1:0]  rf_src,
  input  logic [DATA_W-1:0]  rf_dst_rdata,
  input  logic [DATA_W-1:0]  rf_src_rdata,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               rf_we,
  output logic               done,
  output logic               illegal_op,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               busy
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   rf_dst_q, rf_dst_d;
  logic [ADDR_W-1:0]   rf_src_q, rf_src_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                rf_we_q, rf_we_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                flag_zero_q, flag_zero_d;
  logic                flag_carry_q, flag_carry_d;
  logic                carry_q, carry_d;
  logic                busy_q, busy_d;

  logic [3:0]          op_c;
  logic [DATA_W-1:0]   alu_res_c;
  logic                alu_carry_c;
  logic                alu_we_c;
  logic                alu_illegal_c;
  logic                mul_start_c;
  logic                mul_busy;
  logic                mul_done_c;
  logic [DATA_W-1:0]   mul_product_c;

  seq_mul64 #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start_c),
    .a         (rf_dst_rdata),
    .b         (rf_src_rdata),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  assign op_c = instr_q[OPC_MSB:OPC_LSB];

  // Single-cycle ALU on the register_file read data
  always_comb begin
    alu_res_c     = '0;
    alu_carry_c   = 1'b0;
    alu_we_c      = 1'b1;
    alu_illegal_c = 1'b0;
    case (op_c)
      OP_NOP: alu_we_c = 1'b0;
      OP_ADD: {alu_carry_c, alu_res_c} = {1'b0, rf_dst_rdata} + {1'b0, rf_src_rdata};
      OP_SUB: begin
        alu_res_c   = rf_dst_rdata - rf_src_rdata;
        alu_carry_c = rf_dst_rdata < rf_src_rdata;
      end
      OP_AND: alu_res_c = rf_dst_rdata & rf_src_rdata;
      OP_OR:  alu_res_c = rf_dst_rdata | rf_src_rdata;
      OP_XOR: alu_res_c = rf_dst_rdata ^ rf_src_rdata;
      OP_MOV: alu_res_c = rf_src_rdata;
      OP_SHL: alu_res_c = rf_dst_rdata << rf_src_rdata[SHAMT_W-1:0];
      OP_SHR: alu_res_c = rf_dst_rdata >> rf_src_rdata[SHAMT_W-1:0];
      OP_MUL: alu_res_c = '0;
      OP_LDI: alu_res_c = DATA_W'(instr_q[IMM_MSB:IMM_LSB]);
      default: begin
        alu_we_c      = 1'b0;
        alu_illegal_c = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    rf_dst_d     = rf_dst_q;
    rf_src_d     = rf_src_q;
    rf_wdata_d   = rf_wdata_q;
    rf_we_d      = 1'b0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    carry_d      = carry_q;
    mul_start_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d  = instr;
          rf_dst_d = ADDR_W'(instr[DST_MSB:DST_LSB]);
          rf_src_d = ADDR_W'(instr[SRC_MSB:SRC_LSB]);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_c == OP_MUL) begin
          mul_start_c = 1'b1;
          state_d     = S_MUL;
        end else begin
          rf_wdata_d = alu_res_c;
          rf_we_d    = alu_we_c;
          illegal_d  = alu_illegal_c;
          carry_d    = alu_carry_c;
          done_d     = 1'b1;
          state_d    = S_WB;
        end
      end
      S_MUL: begin
        if (mul_busy && mul_done_c) begin
          rf_wdata_d = mul_product_c;
          rf_we_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = S_WB;
        end
      end
      S_WB: begin
        if (rf_we_q) flag_zero_d = (rf_wdata_q == '0);
        if (op_c == OP_ADD || op_c == OP_SUB) flag_carry_d = carry_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      rf_dst_q     <= '0;
      rf_src_q     <= '0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
      carry_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      rf_dst_q     <= rf_dst_d;
      rf_src_q     <= rf_src_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_we_q      <= rf_we_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
      carry_q      <= carry_d;
      busy_q       <= busy_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign rf_dst      = rf_dst_q;
  assign rf_src      = rf_src_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_we       = rf_we_q;
  assign done        = done_q;
  assign illegal_op  = illegal_q;
  assign flag_zero   = flag_zero_q;
  assign flag_carry  = flag_carry_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage with a behavioural register file.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_dst, rf_src;
  logic [63:0] rf_dst_rdata, rf_src_rdata, rf_wdata;
  logic        rf_we, done, illegal_op, flag_zero, flag_carry, busy;

  alu_exec_stage dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rf_dst       (rf_dst),
    .rf_src       (rf_src),
    .rf_dst_rdata (rf_dst_rdata),
    .rf_src_rdata (rf_src_rdata),
    .rf_wdata     (rf_wdata),
    .rf_we        (rf_we),
    .done         (done),
    .illegal_op   (illegal_op),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, write on rising edge
  logic [63:0] regs [16] = '{default: 64'd0};
  assign rf_dst_rdata = regs[rf_dst];
  assign rf_src_rdata = regs[rf_src];
  always @(posedge clk) if (rf_we) regs[rf_dst] <= rf_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] wdata;
    bit          we;
    bit          ill;
    logic [3:0]  dst;
    int          lat;
    bit          fz;
    bit          fc;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Reference architectural state
  logic [63:0] m_regs [16] = '{default: 64'd0};
  bit m_fz = 1'b0;
  bit m_fc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s);
    return {op, d, s, 4'h0};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] d, input logic [7:0] imm);
    return {4'hA, d, imm};
  endfunction

  // Architectural effect of one instruction, straight from the opcode table
  function automatic exp_t model_exec(input logic [15:0] ins);
    exp_t e;
    logic [3:0]  op;
    logic [63:0] a, b, r;
    bit          c, upd;
    op = ins[15:12];
    e.dst = ins[11:8];
    a = m_regs[ins[11:8]];
    b = m_regs[ins[7:4]];
    r = 64'd0; c = 1'b0; upd = 1'b0;
    e.we = 1'b1; e.ill = 1'b0; e.lat = 1;
    case (op)
      4'h0: e.we = 1'b0;
      4'h1: begin r = a + b; c = (r < a); upd = 1'b1; end
      4'h2: begin r = a - b; c = (a < b); upd = 1'b1; end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = b;
      4'h7: r = a << (b % 64);
      4'h8: r = a >> (b % 64);
      4'h9: begin r = a * b; e.lat = 65; end
      4'hA: r = {56'd0, ins[7:0]};
      default: begin e.we = 1'b0; e.ill = 1'b1; end
    endcase
    if (e.we) begin
      m_regs[e.dst] = r;
      m_fz = (r == 64'd0);
    end
    if (upd) m_fc = c;
    e.wdata = r;
    e.fz = m_fz;
    e.fc = m_fc;
    e.acc = 0;
    return e;
  endfunction

  // Present one instruction and hold it until accepted; called on a falling edge
  task automatic issue(input logic [15:0] ins, input bit retire);
    int n = 0;
    bit ok = 1'b0;
    exp_t e;
    instr = ins;
    instr_valid = 1'b1;
    while (n < 300) begin
      if (instr_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      instr_valid = 1'b0;
      return;
    end
    #1;
    if (retire) begin
      e = model_exec(ins);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !instr_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every retirement is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_we", 64'(rf_we), 64'(e.we));
          chk("wb_illegal", 64'(illegal_op), 64'(e.ill));
          chk("wb_dst", 64'(rf_dst), 64'(e.dst));
          if (e.we) chk("wb_wdata", rf_wdata, e.wdata);
          chk("wb_latency", 64'(cyc - e.acc), 64'(e.lat));
          @(negedge clk);
          chk("flag_zero", 64'(flag_zero), 64'(e.fz));
          chk("flag_carry", 64'(flag_carry), 64'(e.fc));
        end
      end else if (!rst && (rf_we || illegal_op)) begin
        chk("strobe_outside_wb", 64'(rf_we || illegal_op), 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] snap [16];
    int n, bad;
    logic [15:0] ins;
    logic [3:0]  op;

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_rf_dst", 64'(rf_dst), 64'd0);
    chk("rst_rf_src", 64'(rf_src), 64'd0);
    chk("rst_flags", 64'({flag_zero, flag_carry, illegal_op, busy}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_instr_ready", 64'(instr_ready), 64'd1);

    // Simple add
    issue(ldi(4'd1, 8'h05), 1'b1);
    issue(ldi(4'd2, 8'h03), 1'b1);
    issue(mk(4'h1, 4'd1, 4'd2), 1'b1);
    wait_idle();
    chk("add_r1", regs[1], 64'h8);
    chk("add_carry", 64'(flag_carry), 64'd0);
    chk("add_zero", 64'(flag_zero), 64'd0);

    // All-ones plus one wraps to zero with carry
    issue(ldi(4'd3, 8'hFF), 1'b1);
    issue(ldi(4'd9, 8'h08), 1'b1);
    issue(ldi(4'd10, 8'hFF), 1'b1);
    for (int i = 0; i < 7; i++) begin
      issue(mk(4'h7, 4'd3, 4'd9), 1'b1);
      issue(mk(4'h4, 4'd3, 4'd10), 1'b1);
    end
    wait_idle();
    chk("ones_r3", regs[3], 64'hFFFF_FFFF_FFFF_FFFF);
    issue(ldi(4'd4, 8'h01), 1'b1);
    issue(mk(4'h1, 4'd3, 4'd4), 1'b1);
    wait_idle();
    chk("wrap_r3", regs[3], 64'd0);
    chk("wrap_zero", 64'(flag_zero), 64'd1);
    chk("wrap_carry", 64'(flag_carry), 64'd1);

    // Subtract with borrow
    issue(ldi(4'd5, 8'h02), 1'b1);
    issue(ldi(4'd6, 8'h07), 1'b1);
    issue(mk(4'h2, 4'd5, 4'd6), 1'b1);
    wait_idle();
    chk("sub_r5", regs[5], 64'hFFFF_FFFF_FFFF_FFFB);
    chk("sub_borrow", 64'(flag_carry), 64'd1);

    // Multiply, with a competing instruction held valid while busy
    issue(ldi(4'd7, 8'hC8), 1'b1);
    issue(ldi(4'd8, 8'h3B), 1'b1);
    issue(mk(4'h9, 4'd7, 4'd8), 1'b1);
    instr = ldi(4'd1, 8'h55);
    instr_valid = 1'b1;
    n = 0; bad = 0;
    while (busy && n < 200) begin
      if (n == 60) instr_valid = 1'b0;
      if (instr_ready) bad++;
      n++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("mul_busy_cycles", 64'(n), 64'd66);
    chk("mul_no_accept_while_busy", 64'(bad), 64'd0);
    wait_idle();
    chk("mul_r7", regs[7], 64'h2E18);
    chk("mul_r1_untouched", regs[1], 64'h8);

    // Illegal opcode then NOP: no register writes, flags kept
    for (int i = 0; i < 16; i++) snap[i] = regs[i];
    issue(16'hC123, 1'b1);
    issue(16'h0450, 1'b1);
    wait_idle();
    bad = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== snap[i]) bad++;
    chk("nop_illegal_regs_unchanged", 64'(bad), 64'd0);

    // Random traffic against the reference model
    for (int k = 0; k < 120; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hA || $urandom_range(0, 3) == 0)
        ins = ldi(4'($urandom_range(0, 15)), 8'($urandom));
      else
        ins = mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      issue(ins, 1'b1);
    end
    wait_idle();
    bad = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== m_regs[i]) bad++;
    chk("random_regs_match", 64'(bad), 64'd0);

    // Reset in the middle of a multiply
    issue(ldi(4'd11, 8'h0D), 1'b1);
    issue(ldi(4'd12, 8'h11), 1'b1);
    wait_idle();
    issue(mk(4'h9, 4'd11, 4'd12), 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rf_we", 64'(rf_we), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    m_fz = 1'b0;
    m_fc = 1'b0;
    @(negedge clk);
    chk("midrst_instr_ready", 64'(instr_ready), 64'd1);
    chk("midrst_outputs", {rf_wdata[59:0], rf_dst}, 64'd0);
    chk("midrst_src", 64'(rf_src), 64'd0);
    chk("midrst_flags", 64'({flag_zero, flag_carry, illegal_op}), 64'd0);
    repeat (80) @(negedge clk);
    chk("midrst_r11", regs[11], 64'h0D);
    bad = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== m_regs[i]) bad++;
    chk("final_regs_match", 64'(bad), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Single-issue execute/writeback stage sitting directly upstream of register_file.
- Accepts one 16-bit instruction per valid/ready handshake and drives register_file's dst/src read addresses.
- Computes the result from dstRead/srcRead and writes it back through dstWrite/writeEnable.
- Single-cycle ALU ops plus an iterative 64-cycle shift-add multiply.

Parameters:
- DATA_W, 64, register width; must match register_file.
- ADDR_W, 4, register address width (16 registers).
- MUL_CYCLES, 64, multiply iterations; must equal DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept instruction
- instr  in  16  [15:12] opcode, [11:8] dst, [7:4] src, [7:0] also imm8 for LDI; [3:0] otherwise ignored
- rf_dst  out  ADDR_W  to register_file dst (read and write address)
- rf_src  out  ADDR_W  to register_file src
- rf_dst_rdata  in  DATA_W  from register_file dstRead (combinational read)
- rf_src_rdata  in  DATA_W  from register_file srcRead
- rf_wdata  out  DATA_W  to register_file dstWrite
- rf_we  out  1  to register_file writeEnable
- done  out  1  one-cycle pulse, instruction retired
- illegal_op  out  1  valid only with done; opcode B-F
- flag_zero  out  1  sticky until next write: last written result == 0
- flag_carry  out  1  sticky until next ADD/SUB: ADD carry-out / SUB borrow (dst<src unsigned)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all outputs 0 except instr_ready=1.
  - rf_dst, rf_src, rf_wdata, rf_we, done, illegal_op, flag_zero, flag_carry all 0.
  - Reset mid-operation abandons the instruction: no write, no done.
- FSM states: IDLE, EXEC, MUL, WB. instr_ready = (state==IDLE) && !rst.
- IDLE: handshake at edge A (instr_valid && instr_ready) latches instr; state goes to EXEC. rf_dst/rf_src are registered from instr fields at edge A.
- EXEC (cycle after A): register_file reads are combinational. At edge A+1:
  - Opcodes 0-8 and A: result registered into rf_wdata; state goes to WB.
  - Opcode 9: operands loaded into multiplier; counter cleared to 0; state goes to MUL.
- Opcodes:
  - 0 NOP: no write.
  - 1 ADD: {carry,res} = dst + src, 65-bit.
  - 2 SUB: res = dst - src; carry = borrow.
  - 3 AND. 4 OR. 5 XOR.
  - 6 MOV: res = src.
  - 7 SHL: res = dst << src[5:0]. 8 SHR (logical): res = dst >> src[5:0].
  - 9 MUL: res = low DATA_W bits of dst*src, unsigned.
  - A LDI: res = zero-extended instr[7:0].
  - B-F: illegal, no write.
- MUL: one shift-add iteration per edge.
  - If mplier[0]: acc += mcand. Then mcand <<= 1; mplier >>= 1; cnt++.
  - The edge completing iteration MUL_CYCLES (A+65) loads acc into rf_wdata; state goes to WB.
- WB (exactly one cycle): done=1.
  - rf_we=1 unless NOP/illegal.
  - illegal_op=1 for opcodes B-F.
  - register_file commits at the edge ending WB; state returns to IDLE.
- Latency, accept edge to commit edge: A+2 for single-cycle ops, A+66 for MUL. Throughput: one instruction per 3 cycles (non-MUL).
- Outside WB: rf_we, done and illegal_op are 0. rf_dst holds dst through WB, so the write address equals the read address.
- Hazards: the next instruction is accepted no earlier than the cycle after WB, so it reads the committed value. No forwarding is needed.
- Flags update at the WB edge only:
  - flag_zero on any write.
  - flag_carry on ADD/SUB only.
  - NOP/illegal leave both flags unchanged.
- dst==src is legal; both read ports see the same value.
- Shift amounts ≥ 64 are impossible (6-bit field); shift by 0 passes dst unchanged.
- instr_valid during busy is ignored; instr must be held by the producer until ready.

Decomposition:
- Shared package exec_pkg:
  - opcode_t enum (NOP..LDI).
  - state_t enum (IDLE, EXEC, MUL, WB).
  - Instruction field bit-position constants.
  - DATA_W/ADDR_W defaults.
- Natural sub-module: seq_mul64, the iterative shift-add multiplier.
  - Ports: start, operands a/b, busy, done, product.
  - Instantiated once; the FSM waits on its done.

Test Plan:
- Bench instantiates alu_exec_stage driving a real register_file.
- LDI r1,0x05; LDI r2,0x03; ADD r1,r2:
  - r1 = 0x8; rf_we pulses exactly 2 cycles after each accept.
  - flag_carry=0, flag_zero=0.
- r3=0xFFFF_FFFF_FFFF_FFFF (LDI 0xFF, then repeated SHL by 8 / OR with 0xFF), r4=1; ADD r3,r4:
  - r3=0, flag_zero=1, flag_carry=1.
- LDI r5,0x02; LDI r6,0x07; SUB r5,r6:
  - r5 = 0xFFFF_FFFF_FFFF_FFFB, flag_carry=1 (borrow).
- LDI r7,0xC8 (200); LDI r8,0x3B (59); MUL r7,r8:
  - r7 = 0x2E18 (11800); busy for 66 cycles; rf_we only at cycle 66 after accept.
  - instr_valid held high during MUL is not accepted.
- Opcode 0xC, then NOP:
  - done=1 with illegal_op=1, then done=1 with illegal_op=0.
  - Neither writes any register (readback of all 16 registers unchanged); flags unchanged.
- Start MUL; assert rst 20 cycles after accept:
  - No write to dst; next cycle instr_ready=1.
  - All outputs at reset values; flags=0.
